// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state type and default width.
package serial_add_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, the only arithmetic element of the serial datapath.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder time-shared LSB-first over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | one bit-step per cycle, WIDTH steps in total
// DONE  | one-cycle result-valid pulse, then back to IDLE
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_shift;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s, fa_co;
  logic             last_step;

  full_adder_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_step = (cnt_q == LAST);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // New sum bit enters at the MSB so the result is aligned after WIDTH steps.
  always_comb begin
    sum_shift            = sum >> 1;
    sum_shift[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_co;
          sum     <= sum_shift;
          cnt_q   <= cnt_q + CW'(1);
          if (last_step) begin
            cout <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
            // carry_q here is the carry into the MSB
            ovf  <= carry_q ^ fa_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: vector table, corner sequences, random ops vs arithmetic model.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       ovf_s;

  logic       start1 = 1'b0;
  logic [0:0] op_a1 = '0, op_b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf_s)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf_s = 1'b0;
`endif

`ifdef SERIAL_ADD_OVF_EN
  logic ovf1;
`endif

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: {ovf, cout, sum}
  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [8:0] t;
    logic       ov;
    t  = {1'b0, a} + {1'b0, b} + 9'(c);
    ov = (a[7] == b[7]) && (t[7] != a[7]);
    return {ov, t};
  endfunction

  // Runs one WIDTH=8 addition, scrambling inputs (and start) while it runs.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] rs, output logic rco, output logic rov,
                     output int nbusy, output int ndone);
    int guard;
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0; guard = 0;
    rs = '0; rco = 1'b0; rov = 1'b0;
    while (!done && guard < 64) begin
      if (busy) nbusy++;
      op_a  = 8'($urandom);
      op_b  = 8'($urandom);
      cin   = 1'($urandom);
      start = 1'($urandom);
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    if (done) begin
      ndone = 1;
      rs = sum; rco = cout; rov = ovf_s;
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  task automatic check_op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] es, input logic eco, input logic eov);
    logic [7:0] rs;
    logic       rco, rov;
    int         nb, nd;
    op8(a, b, c, rs, rco, rov, nb, nd);
    chk({tag, "_sum"}, 32'(rs), 32'(es));
    chk({tag, "_cout"}, 32'(rco), 32'(eco));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 32'(rov), 32'(eov));
`endif
    chk({tag, "_busy_cycles"}, 32'(nb), 32'd8);
    chk({tag, "_done_pulses"}, 32'(nd), 32'd1);
  endtask

  initial begin
    vec_t       vecs[6];
    logic [9:0] m;
    int         ndone, nbusy, first_done, second_done, guard;
    logic       busy_seen;

    vecs[0] = '{a: 8'h3C, b: 8'h5A, c: 1'b0, s: 8'h96, co: 1'b0, ov: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h00, c: 1'b1, s: 8'h01, co: 1'b0, ov: 1'b0};
    vecs[3] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h00, c: 1'b1, s: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1, ov: 1'b0};

    // Reset state, asserted before any clock edge
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      check_op8($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
                vecs[i].s, vecs[i].co, vecs[i].ov);

    // Result holds in IDLE after the done pulse
    repeat (3) @(negedge clk);
    chk("hold_sum", 32'(sum), 32'hFF);
    chk("hold_cout", 32'(cout), 32'd1);

    // start re-pulsed mid-RUN with different operands is ignored
    @(negedge clk);
    op_a = 8'h3C; op_b = 8'h5A; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    op_a = 8'h11; op_b = 8'h22; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("ign_done_pulses", 32'(ndone), 32'd1);
    chk("ign_sum", 32'(sum), 32'h96);
    chk("ign_busy_after", 32'(busy), 32'd0);

    // Held start: next acceptance only in the IDLE cycle after DONE
    @(negedge clk);
    op_a = 8'h01; op_b = 8'h01; cin = 1'b0; start = 1'b1;
    first_done = -1; second_done = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = i;
        else if (second_done < 0) second_done = i;
      end
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(first_done), 32'd8);
    chk("b2b_done_spacing", 32'(second_done - first_done), 32'd10);
    repeat (12) @(negedge clk);

    // Asynchronous reset in RUN aborts the operation
    op_a = 8'h3C; op_b = 8'h5A; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("arst_ovf", 32'(ovf_s), 32'd0);
`endif
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("arst_no_activity", 32'(ndone), 32'd0);
    rst = 1'b0;
    op_a = 8'h01; op_b = 8'h02; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_first_accept", 32'(busy), 32'd1);
    guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("post_rst_done_seen", 32'(done), 32'd1);
    chk("post_rst_sum", 32'(sum), 32'h03);
    @(negedge clk);

    // WIDTH=1 instance: exhaustive over a, b, cin
    for (int v = 0; v < 8; v++) begin
      logic [1:0] t;
      t = 2'(v & 1) + 2'((v >> 1) & 1) + 2'((v >> 2) & 1);
      @(negedge clk);
      op_a1 = 1'(v); op_b1 = 1'(v >> 1); cin1 = 1'(v >> 2); start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      op_a1 = ~op_a1; op_b1 = ~op_b1; cin1 = ~cin1;
      busy_seen = busy1;
      chk($sformatf("w1_%0d_busy", v), 32'(busy1), 32'd1);
      @(negedge clk);
      chk($sformatf("w1_%0d_done", v), 32'({busy1, done1}), 32'b01);
      chk($sformatf("w1_%0d_sum", v), 32'(sum1), 32'(t[0]));
      chk($sformatf("w1_%0d_cout", v), 32'(cout1), 32'(t[1]));
      @(negedge clk);
      chk($sformatf("w1_%0d_idle", v), 32'({busy1, done1}), 32'b00);
    end

    // Random operations against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a, b;
      logic       c;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      m = model8(a, b, c);
      check_op8($sformatf("rnd%0d", i), a, b, c, m[7:0], m[8], m[9]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
